// File: rtl/rd53_afe_model_mc.sv
// rd53_afe_model_mc: clocked behavioural model of a multi-channel pixel analog
// front end. Each channel turns injected charge into a HIT pulse whose length
// is the time-over-threshold. The model covers threshold trim, gain selection,
// power-down, calibration injection, retrigger, dead time and lost-charge
// reporting.
module rd53_afe_model_mc #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CHARGE_W = 8,
    parameter int unsigned TRIM_W   = 4,
    parameter int unsigned TOT_W    = 4,
    parameter int unsigned DEADTIME = 2,
    parameter int unsigned CAL_Q_HI = 100,
    parameter int unsigned CAL_Q_MI = 20
) (
    input  logic                      CLK_BX,
    input  logic                      RST_B,
    input  logic [NCH*CHARGE_W-1:0]   PIXEL_Q,
    input  logic [NCH-1:0]            PIXEL_Q_VALID,
    input  logic [CHARGE_W-1:0]       VTH,
    input  logic [NCH*TRIM_W-1:0]     TH_DAC,
    input  logic [NCH-1:0]            GAIN_SEL,
    input  logic [NCH-1:0]            POWER_DOWN,
    input  logic [NCH-1:0]            CAL_EN,
    input  logic                      CAL_HI,
    input  logic                      CAL_MI,
    output logic [NCH-1:0]            HIT,
    output logic [NCH-1:0]            LOST
);

    localparam int unsigned THR_W    = CHARGE_W + 2;
    localparam int unsigned Q_MAX    = (1 << CHARGE_W) - 1;
    localparam int unsigned TOT_MAX  = (1 << TOT_W) - 1;
    localparam int unsigned TRIM_MID = 1 << (TRIM_W - 1);
    localparam int unsigned DCNT_W   = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_DEAD = 2'd2
    } ch_state_t;

    logic cal_hi_q;
    logic cal_mi_q;
    logic hi_rise;
    logic mi_rise;

    // Previous-cycle strobe levels; global, so they keep tracking while channels are powered down.
    always_ff @(posedge CLK_BX) begin
        // NOTE: reset is sampled on the clock edge like any other input, so it sits inside the clocked block.
        if (!RST_B) begin
            cal_hi_q <= 1'b0;
            cal_mi_q <= 1'b0;
        end else begin
            cal_hi_q <= CAL_HI;
            cal_mi_q <= CAL_MI;
        end
    end

    assign hi_rise = CAL_HI & ~cal_hi_q;
    assign mi_rise = CAL_MI & ~cal_mi_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CHARGE_W-1:0]     pix_q;
        logic [TRIM_W-1:0]       trim;
        logic signed [THR_W-1:0] thr_raw;
        logic [CHARGE_W-1:0]     thr;
        logic [31:0]             q_sum;
        logic [CHARGE_W-1:0]     q;
        logic [CHARGE_W-1:0]     excess;
        logic [31:0]             tot_full;
        logic [TOT_W-1:0]        tot;
        logic                    qual;
        ch_state_t               state;
        logic [TOT_W-1:0]        cnt;
        logic [TOT_W-1:0]        cnt_dec;
        logic [DCNT_W-1:0]       dcnt;
        logic                    hit_q;
        logic                    lost_q;

        assign pix_q   = PIXEL_Q[i*CHARGE_W +: CHARGE_W];
        assign trim    = TH_DAC[i*TRIM_W +: TRIM_W];
        assign cnt_dec = cnt - TOT_W'(1);

        // Effective threshold, saturated charge sum and resulting ToT for this cycle.
        always_comb begin
            // NOTE: every signal is given a value up front so no path through the block infers a latch.
            thr      = CHARGE_W'(1);
            q_sum    = '0;
            thr_raw  = $signed({2'b00, VTH}) + $signed(THR_W'(trim)) - $signed(THR_W'(TRIM_MID));
            // Floor of 1 keeps zero charge from ever firing; ceiling is the charge range.
            if (thr_raw[THR_W-1] || (thr_raw == '0)) begin
                thr = CHARGE_W'(1);
            end else if (|thr_raw[THR_W-2:CHARGE_W]) begin
                thr = CHARGE_W'(Q_MAX);
            end else begin
                thr = thr_raw[CHARGE_W-1:0];
            end
            if (PIXEL_Q_VALID[i]) begin
                q_sum = 32'(pix_q);
            end
            if (CAL_EN[i]) begin
                if (hi_rise) q_sum = q_sum + CAL_Q_HI;
                if (mi_rise) q_sum = q_sum + CAL_Q_MI;
            end
            q        = (q_sum > Q_MAX) ? CHARGE_W'(Q_MAX) : q_sum[CHARGE_W-1:0];
            qual     = (q >= thr) && (q != '0);
            excess   = q - thr;
            tot_full = (GAIN_SEL[i] ? 32'(excess >> 2) : 32'(excess >> 1)) + 32'd1;
            tot      = (tot_full > TOT_MAX) ? TOT_W'(TOT_MAX) : tot_full[TOT_W-1:0];
        end

        // Per-channel IDLE/HIT/DEAD sequencer; power-down aborts exactly like reset, without dead time.
        always_ff @(posedge CLK_BX) begin
            // NOTE: non-blocking assignments so every register here sees the pre-edge values of the others.
            if (!RST_B || POWER_DOWN[i]) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                dcnt   <= '0;
                hit_q  <= 1'b0;
                lost_q <= 1'b0;
            end else begin
                lost_q <= 1'b0;
                unique case (state)
                    ST_IDLE: begin
                        if (qual) begin
                            state <= ST_HIT;
                            cnt   <= tot;
                            hit_q <= 1'b1;
                        end
                    end
                    ST_HIT: begin
                        if (qual) begin
                            cnt <= (cnt_dec > tot) ? cnt_dec : tot;
                        end else if (cnt <= TOT_W'(1)) begin
                            cnt   <= '0;
                            hit_q <= 1'b0;
                            if (DEADTIME == 0) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DEAD;
                                dcnt  <= DCNT_W'(DEADTIME);
                            end
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                    ST_DEAD: begin
                        lost_q <= qual;
                        if (dcnt <= DCNT_W'(1)) begin
                            state <= ST_IDLE;
                            dcnt  <= '0;
                        end else begin
                            dcnt <= dcnt - DCNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        hit_q <= 1'b0;
                    end
                endcase
            end
        end

        assign HIT[i]  = hit_q;
        assign LOST[i] = lost_q;
    end

endmodule
